// File: rtl/vector_drain_pkg.sv
// Shared types and helpers for the vector_drain lane-serialising buffer.
// Optional feature macro: VECTOR_DRAIN_OVERFLOW_COUNT_EN (dropped-vector counter).
package vector_drain_pkg;

  localparam int unsigned N_DEF          = 8;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned OVF_W          = 16;

  // Default-configuration vector: lane 0 is element [0]
  typedef logic [DATA_WIDTH_DEF-1:0] vector_t [N_DEF];

  function automatic int unsigned lane_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vector_drain_if.sv
// Push and lane-read handshake bundle for vector_drain.
// overflow_count exists only when VECTOR_DRAIN_OVERFLOW_COUNT_EN is defined.
interface vector_drain_if
  import vector_drain_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned LW = lane_w(N);

  logic                  valid_in;
  logic                  eof_in;
  logic [DATA_WIDTH-1:0] vector_in [N];
  logic                  ready_in;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [LW-1:0]         rd_lane;
  logic                  rd_last;
`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
  logic [OVF_W-1:0]      overflow_count;
`endif

  modport slave (
    input  valid_in, eof_in, vector_in, rd_ready,
    output ready_in, rd_valid, rd_data, rd_lane, rd_last
`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
    , output overflow_count
`endif
  );

  modport master (
    output valid_in, eof_in, vector_in, rd_ready,
    input  ready_in, rd_valid, rd_data, rd_lane, rd_last
`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
    , input overflow_count
`endif
  );

endinterface

// File: rtl/vector_drain.sv
// Buffers whole N-lane vectors and drains them one lane word per handshake.
// Define VECTOR_DRAIN_OVERFLOW_COUNT_EN to add a saturating dropped-vector counter.
module vector_drain
  import vector_drain_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OB_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  vector_drain_if.slave  bus
);

  localparam int unsigned    LW        = lane_w(N);
  localparam int unsigned    PW        = $clog2(OB_DEPTH);
  localparam int unsigned    CW        = PW + 1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(N - 1);
  localparam logic [CW-1:0]  DEPTH     = CW'(OB_DEPTH);

  logic [DATA_WIDTH-1:0] data_q [OB_DEPTH][N];
  logic [OB_DEPTH-1:0]   eof_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  not_full, rd_valid, beat, pop, push;

  // Acceptance looks only at the registered occupancy, never at the read side
  assign not_full = (count_q < DEPTH);
  assign rd_valid = !reset && (count_q != '0);
  assign beat     = rd_valid && bus.rd_ready;
  assign pop      = beat && (lane_q == LAST_LANE);
  assign push     = !reset && bus.valid_in && not_full;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      lane_d   = '0;
    end else if (beat) begin
      lane_d   = lane_q + LW'(1);
    end
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lane_q   <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; occupancy alone decides what is live
  always_ff @(posedge clk) begin
    if (push) begin
      for (int i = 0; i < int'(N); i++) data_q[wr_ptr_q][i] <= bus.vector_in[i];
      eof_q[wr_ptr_q] <= bus.eof_in;
    end
  end

  assign bus.ready_in = reset || not_full;
  assign bus.rd_valid = rd_valid;
  assign bus.rd_data  = rd_valid ? data_q[rd_ptr_q][lane_q] : '0;
  assign bus.rd_lane  = reset ? '0 : lane_q;
  assign bus.rd_last  = rd_valid && (lane_q == LAST_LANE) && eof_q[rd_ptr_q];

`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
  logic             drop;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  assign drop = !reset && bus.valid_in && !not_full;

  always_comb begin
    ovf_d = ovf_q;
    if (drop && (ovf_q != '1)) ovf_d = ovf_q + OVF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ovf_q <= '0;
    else       ovf_q <= ovf_d;
  end

  assign bus.overflow_count = ovf_q;
`endif

endmodule

// File: tb/tb_vector_drain.sv
// Self-checking bench for vector_drain: queue-based reference model plus directed literal checks.
module tb_vector_drain;

  localparam int unsigned N     = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  typedef logic [N-1:0][DW-1:0] vec_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vector_drain_if #(.N(N), .DATA_WIDTH(DW)) bus ();

  vector_drain #(.N(N), .DATA_WIDTH(DW), .OB_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO of whole vectors plus the index of the next lane to emit
  vec_t md[$];
  bit   me[$];
  int   mlane = 0;
  int   movf  = 0;

  always @(negedge clk) begin
    bit            e_ready, e_valid, e_last, can_push;
    logic [DW-1:0] e_data;
    int            e_lane;
    vec_t          v;
    e_ready = reset || (md.size() < DEPTH);
    e_valid = !reset && (md.size() != 0);
    e_data  = e_valid ? md[0][mlane] : '0;
    e_lane  = reset ? 0 : mlane;
    e_last  = e_valid && (mlane == N - 1) && me[0];
    chk("ready_in", 64'(bus.ready_in), 64'(e_ready));
    chk("rd_valid", 64'(bus.rd_valid), 64'(e_valid));
    chk("rd_data",  64'(bus.rd_data),  64'(e_data));
    chk("rd_lane",  64'(bus.rd_lane),  64'(e_lane));
    chk("rd_last",  64'(bus.rd_last),  64'(e_last));
`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
    chk("overflow_count", 64'(bus.overflow_count), 64'(movf));
`endif
    if (reset) begin
      md.delete();
      me.delete();
      mlane = 0;
      movf  = 0;
    end else begin
      can_push = (md.size() < DEPTH);
      if (e_valid && bus.rd_ready) begin
        mlane++;
        if (mlane == N) begin
          mlane = 0;
          void'(md.pop_front());
          void'(me.pop_front());
        end
      end
      if (bus.valid_in) begin
        if (can_push) begin
          for (int i = 0; i < N; i++) v[i] = bus.vector_in[i];
          md.push_back(v);
          me.push_back(bus.eof_in);
        end else if (movf < 65535) begin
          movf++;
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [DW-1:0] base, input bit rnd);
    for (int i = 0; i < N; i++) bus.vector_in[i] = rnd ? DW'($urandom) : base + DW'(i);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int t, budget, bias_v, bias_r;
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.eof_in   = 1'b0;
    bus.rd_ready = 1'b0;
    set_vec('0, 1'b0);
    repeat (2) cycle();
    #2;
    chk("rst_ready_in", 64'(bus.ready_in), 64'd1);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data",  64'(bus.rd_data),  64'd0);
    reset = 1'b0;
    cycle();
    #2;
    chk("post_rst_rd_lane", 64'(bus.rd_lane), 64'd0);
    chk("post_rst_rd_last", 64'(bus.rd_last), 64'd0);

    // Single eof vector drained at full rate
    cycle();
    bus.valid_in = 1'b1; bus.eof_in = 1'b1; bus.rd_ready = 1'b1;
    set_vec(32'h10, 1'b0);
    cycle();
    bus.valid_in = 1'b0; bus.eof_in = 1'b0;
    for (int i = 0; i < N; i++) begin
      #2;
      chk("seq_rd_data", 64'(bus.rd_data), 64'(32'h10 + i));
      chk("seq_rd_last", 64'(bus.rd_last), 64'(i == N - 1));
      cycle();
    end
    #2;
    chk("seq_drained", 64'(bus.rd_valid), 64'd0);

    // Five back-to-back pushes with no reads: fifth is dropped
    cycle();
    bus.rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      bus.valid_in = 1'b1; bus.eof_in = k[0];
      set_vec(32'h100 * (k + 1), 1'b0);
      #2;
      chk("fill_ready_in", 64'(bus.ready_in), 64'(k < 4));
      cycle();
    end
    bus.valid_in = 1'b0;
    #2;
    chk("full_ready_in", 64'(bus.ready_in), 64'd0);
`ifdef VECTOR_DRAIN_OVERFLOW_COUNT_EN
    chk("ovf_one", 64'(bus.overflow_count), 64'd1);
`endif
    // Full, then continuous push with continuous read
    bus.valid_in = 1'b1; bus.rd_ready = 1'b1;
    for (int c = 0; c < 60; c++) begin
      set_vec(32'h2000 + 32'(c << 4), 1'b0);
      bus.eof_in = c[1];
      cycle();
    end
    bus.valid_in = 1'b0;
    repeat (40) cycle();
    #2;
    chk("cont_drained", 64'(bus.rd_valid), 64'd0);

    // Toggling rd_ready during a drain
    for (int k = 0; k < 2; k++) begin
      bus.valid_in = 1'b1; bus.eof_in = 1'b1;
      set_vec(32'h500 + 32'(k << 4), 1'b0);
      cycle();
    end
    bus.valid_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      bus.rd_ready = c[0];
      cycle();
    end

    // Ten tagged vectors across two pointer wraps
    bus.rd_ready = 1'b1;
    t = 0; budget = 0;
    while (t < 10 && budget < 300) begin
      bus.valid_in = 1'b1; bus.eof_in = (t == 9);
      set_vec(32'(t) << 8, 1'b0);
      #2;
      if (bus.ready_in) t++;
      cycle();
      budget++;
    end
    chk("tag_push_budget", 64'(t), 64'd10);
    bus.valid_in = 1'b0;
    repeat (90) cycle();
    #2;
    chk("tag_count_zero", 64'(bus.rd_valid), 64'd0);

    // Reset in the middle of a vector
    bus.valid_in = 1'b1; bus.eof_in = 1'b1;
    set_vec(32'h30, 1'b0);
    cycle();
    bus.valid_in = 1'b0;
    repeat (4) cycle();
    #2;
    chk("mid_rd_lane", 64'(bus.rd_lane), 64'd4);
    reset = 1'b1;
    #1;
    chk("mid_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    cycle();
    reset = 1'b0;
    #2;
    chk("after_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("after_rst_ready_in", 64'(bus.ready_in), 64'd1);
    cycle();
    bus.valid_in = 1'b1; bus.eof_in = 1'b0;
    set_vec(32'h40, 1'b0);
    cycle();
    bus.valid_in = 1'b0;
    #2;
    chk("repush_rd_lane", 64'(bus.rd_lane), 64'd0);
    chk("repush_rd_data", 64'(bus.rd_data), 64'h40);
    repeat (10) cycle();

    // Randomised traffic with varying push/read pressure and rare resets
    for (int blk = 0; blk < 8; blk++) begin
      bias_v = $urandom_range(1, 9);
      bias_r = $urandom_range(1, 9);
      for (int c = 0; c < 400; c++) begin
        reset        = ($urandom_range(0, 299) == 0);
        bus.valid_in = ($urandom_range(0, 9) < bias_v);
        bus.rd_ready = ($urandom_range(0, 9) < bias_r);
        bus.eof_in   = 1'($urandom);
        set_vec('0, 1'b1);
        cycle();
      end
    end
    reset = 1'b0; bus.valid_in = 1'b0; bus.rd_ready = 1'b1;
    repeat (40) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_drain.md
VECTOR_DRAIN -- requirements
Module: vector_drain

Interface
REQ-001 Parameter N, default 8: lanes per vector.
REQ-002 Parameter DATA_WIDTH, default 32: bits per lane.
REQ-003 Parameter OB_DEPTH, default 4: vector entries held; power of two, >=2.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 valid_in  input  1  vector_in/eof_in carry a vector this cycle.
REQ-007 eof_in  input  1  vector is the final vector of a frame.
REQ-008 vector_in  input  N x DATA_WIDTH  unpacked vector; lane 0 is vector_in[0].
REQ-009 ready_in  output  1  buffer can accept a vector this cycle.
REQ-010 rd_ready  input  1  host accepts rd_data this cycle.
REQ-011 rd_valid  output  1  rd_data holds a valid lane word.
REQ-012 rd_data  output  DATA_WIDTH  current lane word.
REQ-013 rd_lane  output  $clog2(N)  lane index of rd_data.
REQ-014 rd_last  output  1  rd_data is lane N-1 of an eof-tagged vector.
REQ-015 overflow_count  output  16  dropped-vector count (present only per REQ-032).

Function
REQ-016 Push: vector_in and eof_in are stored at wr_ptr when valid_in && ready_in; wr_ptr increments modulo OB_DEPTH.
REQ-017 ready_in = (count < OB_DEPTH), derived from registered count only, never from rd_ready.
REQ-018 valid_in while full: vector dropped, no state change except REQ-032 counter; a same-cycle pop does not admit it.
REQ-019 count has width $clog2(OB_DEPTH)+1; +1 on push-only, -1 on pop-only, unchanged on push+pop in the same cycle.
REQ-020 rd_valid = (count != 0); a vector pushed in cycle t is first visible on rd_valid in cycle t+1.
REQ-021 rd_data = stored lane rd_lane of entry rd_ptr; rd_data drives 0 while rd_valid=0.
REQ-022 Lane handshake: rd_valid && rd_ready advances rd_lane by 1; lanes are emitted in order 0..N-1.
REQ-023 Pop: handshake at rd_lane=N-1 resets rd_lane to 0 and increments rd_ptr modulo OB_DEPTH.
REQ-024 rd_last = rd_valid && (rd_lane==N-1) && stored eof of entry rd_ptr.
REQ-025 rd_ready=0 holds rd_data, rd_lane, rd_last stable while rd_valid=1.
REQ-026 Throughput: one lane word per cycle with rd_ready held high; a full vector drains in N cycles.
REQ-027 Pointer wrap: wr_ptr/rd_ptr wrap OB_DEPTH-1 -> 0 without loss or duplication.

Reset
REQ-028 reset clears wr_ptr, rd_ptr, rd_lane, count and, when compiled in, overflow_count to 0.
REQ-029 Outputs in the reset cycle and the next cycle: ready_in=1, rd_valid=0, rd_data=0, rd_lane=0, rd_last=0.
REQ-030 Reset mid-vector discards all stored entries and partial lane progress; stored data contents need not be cleared.
REQ-031 reset has priority over a simultaneous push or pop.

Configuration
REQ-032 With VECTOR_DRAIN_OVERFLOW_COUNT_EN defined: overflow_count increments by 1 for each REQ-018 drop and saturates at 16'hFFFF.
REQ-033 Without VECTOR_DRAIN_OVERFLOW_COUNT_EN: overflow_count port and counter are absent; drops are silent.

Structure
REQ-034 Shared package holds the lane-index width function, the vector type (N x DATA_WIDTH), and the overflow counter width constant 16.
REQ-035 Storage is a register array inside vector_drain, with no RAM, so read latency is zero; no sub-module is instantiated.

Verification (N=8, DATA_WIDTH=32, OB_DEPTH=4)
REQ-036 Push one vector with lanes 0x10..0x17 and eof=1, rd_ready=1 -> rd_data 0x10..0x17 over 8 consecutive cycles starting the cycle after push; rd_last=1 only on 0x17.
REQ-037 Push 5 vectors back-to-back with rd_ready=0 -> ready_in=0 after the 4th; the 5th is dropped; overflow_count=1 (macro defined).
REQ-038 Fill to 4 entries, then rd_ready=1 with valid_in=1 continuously -> ready_in rises the cycle after each pop; a push is never accepted on a full-count cycle.
REQ-039 Toggle rd_ready 1/0 every cycle during a drain -> each lane appears exactly once, held stable while rd_ready=0.
REQ-040 Push and drain 10 vectors tagged 0..9 -> output order 0..9 across two pointer wraps, with count returning to 0.
REQ-041 Assert reset after lane 3 of entry 0 -> next cycle rd_valid=0, ready_in=1; the next push is emitted starting at lane 0.
